// File: rtl/regfile_2r1w_32x32_drv_if.sv
// Bus between core logic, the 2R1W 32x32 port driver and the array macro.
// Addresses and data use ascending ranges so that bit 0 is the MSB.
interface regfile_2r1w_32x32_drv_if;
  logic        ready;
  logic        rd0_req,  rd1_req;
  logic [0:4]  rd0_adr,  rd1_adr;
  logic        rd0_vld,  rd1_vld;
  logic [0:31] rd0_dat,  rd1_dat;
  logic        wr0_req;
  logic [0:4]  wr0_adr;
  logic [0:31] wr0_dat;

  logic rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4;
  logic rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4;
  logic wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4;

  logic [0:31] arr_wr0_dat;
  logic [0:31] arr_rd0_dat, arr_rd1_dat;

  // Driver view
  modport slave (
    input  rd0_req, rd1_req, rd0_adr, rd1_adr, wr0_req, wr0_adr, wr0_dat,
    input  arr_rd0_dat, arr_rd1_dat,
    output ready, rd0_vld, rd1_vld, rd0_dat, rd1_dat, arr_wr0_dat,
    output rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4,
    output rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4,
    output wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4
  );

  // Core plus array view
  modport master (
    output rd0_req, rd1_req, rd0_adr, rd1_adr, wr0_req, wr0_adr, wr0_dat,
    output arr_rd0_dat, arr_rd1_dat,
    input  ready, rd0_vld, rd1_vld, rd0_dat, rd1_dat, arr_wr0_dat,
    input  rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4,
    input  rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4,
    input  wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4
  );
endinterface

// File: rtl/regfile_2r1w_32x32_drv.sv
// Port driver for the 2R1W 32x32 register-file array: registered predecode,
// read capture with same-edge write bypass, and optional post-reset init sweep.
module regfile_2r1w_32x32_drv #(
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter logic [31:0] INIT_VALUE    = 32'h00000000
) (
  input logic clk,
  input logic rst,
  regfile_2r1w_32x32_drv_if.slave bus
);
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAST = 31;

  typedef enum logic [1:0] {RST, INIT, RUN} state_t;

  typedef struct packed {
    logic c_na0, c_a0, na1_na2, na1_a2, a1_na2, a1_a2, na3, a3, na4, a4;
  } pd_t;

  function automatic pd_t predecode(input logic en, input logic [0:AW-1] a);
    pd_t p;
    p.c_na0   = en & ~a[0];
    p.c_a0    = en &  a[0];
    p.na1_na2 = en & ~a[1] & ~a[2];
    p.na1_a2  = en & ~a[1] &  a[2];
    p.a1_na2  = en &  a[1] & ~a[2];
    p.a1_a2   = en &  a[1] &  a[2];
    p.na3     = en & ~a[3];
    p.a3      = en &  a[3];
    p.na4     = en & ~a[4];
    p.a4      = en &  a[4];
    return p;
  endfunction

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt;
  logic            ready_q;
  logic            init_wr, cnt_inc;
  logic [0:AW-1]   init_adr;
  logic            rd0_acc, rd1_acc, wr_acc, wr_en_nxt;
  logic [0:AW-1]   wr_adr_nxt;
  logic [0:DW-1]   wr_dat_nxt;

  pd_t             rd0_pd, rd1_pd, wr_pd;
  logic            rd0_en_q, rd1_en_q, wr_en_q;
  logic [0:AW-1]   rd0_adr_q, rd1_adr_q, wr_adr_q;
  logic [0:DW-1]   wr_dat_q, rd0_dat_q, rd1_dat_q;
  logic            rd0_vld_q, rd1_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST;
    else     state <= state_nxt;
  end

  // Next state plus the init-sweep write source: cnt is the address on the wr0 lines
  always_comb begin
    state_nxt = state;
    init_wr   = 1'b0;
    cnt_inc   = 1'b0;
    init_adr  = '0;
    case (state)
      RST: begin
        state_nxt = INIT_ON_RESET ? INIT : RUN;
        init_wr   = INIT_ON_RESET;
      end
      INIT: begin
        if (cnt == AW'(LAST)) begin
          state_nxt = RUN;
        end else begin
          init_wr  = 1'b1;
          cnt_inc  = 1'b1;
          init_adr = cnt + AW'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = RST;
    endcase
  end

  assign rd0_acc    = bus.rd0_req & ready_q;
  assign rd1_acc    = bus.rd1_req & ready_q;
  assign wr_acc     = bus.wr0_req & ready_q;
  assign wr_en_nxt  = wr_acc | init_wr;
  assign wr_adr_nxt = init_wr ? init_adr : bus.wr0_adr;
  assign wr_dat_nxt = init_wr ? INIT_VALUE : bus.wr0_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ready_q   <= 1'b0;
      rd0_pd    <= '0;
      rd1_pd    <= '0;
      wr_pd     <= '0;
      rd0_en_q  <= 1'b0;
      rd1_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd0_adr_q <= '0;
      rd1_adr_q <= '0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      rd0_vld_q <= 1'b0;
      rd1_vld_q <= 1'b0;
      rd0_dat_q <= '0;
      rd1_dat_q <= '0;
    end else begin
      if (cnt_inc) cnt <= cnt + AW'(1);
      ready_q   <= (state_nxt == RUN);
      rd0_pd    <= predecode(rd0_acc, bus.rd0_adr);
      rd1_pd    <= predecode(rd1_acc, bus.rd1_adr);
      wr_pd     <= predecode(wr_en_nxt, wr_adr_nxt);
      rd0_en_q  <= rd0_acc;
      rd1_en_q  <= rd1_acc;
      wr_en_q   <= wr_en_nxt;
      if (rd0_acc)   rd0_adr_q <= bus.rd0_adr;
      if (rd1_acc)   rd1_adr_q <= bus.rd1_adr;
      if (wr_en_nxt) begin
        wr_adr_q <= wr_adr_nxt;
        wr_dat_q <= wr_dat_nxt;
      end
      rd0_vld_q <= rd0_en_q;
      rd1_vld_q <= rd1_en_q;
      // Write-first: a same-edge write to the read address overrides the array
      if (rd0_en_q)
        rd0_dat_q <= (wr_en_q && wr_adr_q == rd0_adr_q) ? wr_dat_q : bus.arr_rd0_dat;
      if (rd1_en_q)
        rd1_dat_q <= (wr_en_q && wr_adr_q == rd1_adr_q) ? wr_dat_q : bus.arr_rd1_dat;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.rd0_vld     = rd0_vld_q;
  assign bus.rd1_vld     = rd1_vld_q;
  assign bus.rd0_dat     = rd0_dat_q;
  assign bus.rd1_dat     = rd1_dat_q;
  assign bus.arr_wr0_dat = wr_dat_q;

  assign {bus.rd0_c_na0, bus.rd0_c_a0, bus.rd0_na1_na2, bus.rd0_na1_a2, bus.rd0_a1_na2,
          bus.rd0_a1_a2, bus.rd0_na3, bus.rd0_a3, bus.rd0_na4, bus.rd0_a4} = rd0_pd;
  assign {bus.rd1_c_na0, bus.rd1_c_a0, bus.rd1_na1_na2, bus.rd1_na1_a2, bus.rd1_a1_na2,
          bus.rd1_a1_a2, bus.rd1_na3, bus.rd1_a3, bus.rd1_na4, bus.rd1_a4} = rd1_pd;
  assign {bus.wr0_c_na0, bus.wr0_c_a0, bus.wr0_na1_na2, bus.wr0_na1_a2, bus.wr0_a1_na2,
          bus.wr0_a1_a2, bus.wr0_na3, bus.wr0_a3, bus.wr0_na4, bus.wr0_a4} = wr_pd;
endmodule

// File: doc/regfile_2r1w_32x32_drv.md
# regfile_2r1w_32x32_drv

Port driver for the 2-read/1-write 32x32 register-file macro. It sits between core logic and the array. It takes binary addresses with request strobes, registers them, and drives the array's predecoded one-hot address groups (c_a0/c_na0, a1a2 quad, a3 pair, a4 pair) per port. It captures array read data into registered outputs with same-cycle write bypass, and runs an optional post-reset initialization sweep over all 32 entries.

## Interface
Parameters:
- INIT_ON_RESET, 1, when 1 write INIT_VALUE to all 32 entries after reset before accepting requests
- INIT_VALUE, 32'h00000000, data written by the init sweep

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ready  out  1  high when requests are accepted
- rd0_req, rd1_req  in  1  read request strobe per port
- rd0_adr, rd1_adr  in  [0:4]  read address, bit 0 = MSB
- rd0_vld, rd1_vld  out  1  read data valid, one-cycle pulse
- rd0_dat, rd1_dat  out  [0:31]  registered read data
- wr0_req  in  1  write request strobe
- wr0_adr  in  [0:4]  write address
- wr0_dat  in  [0:31]  write data
- {p}_c_na0, {p}_c_a0, {p}_na1_na2, {p}_na1_a2, {p}_a1_na2, {p}_a1_a2, {p}_na3, {p}_a3, {p}_na4, {p}_a4  out  1 each  predecoded address to array, for p in rd0, rd1, wr0 (30 lines)
- arr_wr0_dat  out  [0:31]  write data to array
- arr_rd0_dat, arr_rd1_dat  in  [0:31]  array read data

## Operation
- FSM states: RST, INIT, RUN.
  - Async rst forces RST.
  - First edge after rst deasserts: RST goes to INIT if INIT_ON_RESET=1, else to RUN.
  - INIT: 5-bit counter 0..31. Each cycle, write port drives counter address with INIT_VALUE. After address 31 is issued, go to RUN.
  - ready = 1 only in RUN.
- Requests are sampled only when ready=1. Requests with ready=0 are dropped: no vld, no array activity. Back-to-back requests every cycle are legal on all three ports independently.
- Predecode of a registered request on port p with address a (en = request registered):
  - c_a0 = en&a0; c_na0 = en&~a0
  - a1_a2 = en&a1&a2; a1_na2 = en&a1&~a2; na1_a2 = en&~a1&a2; na1_na2 = en&~a1&~a2
  - a3 = en&a3; na3 = en&~a3; a4 = en&a4; na4 = en&~a4
- Idle port: all 10 lines low. Active port: exactly one line high in each group.
- All predecode outputs and arr_wr0_dat come directly from flops (glitch-free). The array tolerates no combinational settling.
- Read capture: rd_dat is loaded from arr_rd_dat only when that port's request is in flight. Otherwise rd_dat holds its last value (array output is X when idle).
- Bypass: if a read and a write to the same address are accepted on the same edge, rd_dat = wr0_dat of that write (write-first). A read accepted one or more edges after a write sees the new data from the array; no bypass is needed.
- Two reads of the same address on the same edge are legal and return identical data.

## Timing
- Request accepted at edge E0. Predecode lines are valid E0..E1. Read data captured at E1. rd_vld is high for the cycle E1..E2. Read latency = 1 cycle after acceptance.
- Write accepted at E0 is driven to the array during E0..E1 and is committed before E1.
- Init: 32 cycles in INIT (wr0_c_* active each cycle). ready rises on the edge after address 31 is issued, so the first accepted request is on the 34th edge after rst deasserts.
- Reset values (held while rst=1): ready=0, rd0_vld=rd1_vld=0, rd0_dat=rd1_dat=0, all 30 predecode lines=0, arr_wr0_dat=0, init counter=0.
- rst asserted mid-INIT or mid-read: outputs go to reset values immediately, no vld is generated, and the init sweep restarts from address 0.

## Test plan
- Reset then init (INIT_ON_RESET=1, INIT_VALUE=32'hA5A5A5A5) -> ready low for 33 edges; then reads of addresses 0, 17, 31 each return A5A5A5A5 with rd_vld one cycle after the request.
- Write 5'd9 = 32'hDEADBEEF, next cycle read 9 on rd0 and rd1 -> both return DEADBEEF, vld one cycle after the request.
- Same-edge write 5'd3 = 32'h12345678 with rd0 read 3 -> rd0_dat = 12345678 (bypass); rd1 reading 4 in the same cycle returns prior contents of 4.
- Predecode check: write to 5'b10110 -> wr0_c_a0, wr0_na1_a2, wr0_a3, wr0_na4 high, all other wr0 lines low for exactly one cycle. Idle ports show all lines 0.
- Requests issued while ready=0 during INIT -> no vld, and array contents are unchanged at the 32 init values.
- rst pulsed at init counter 12 -> all outputs reset asynchronously, the sweep restarts at address 0, and ready rises 33 edges after the deassert.
